// File: rtl/spi_flash_read.sv
// spi_flash_read: reads an inclusive byte range from a 4-byte-address (Q)SPI NOR
// flash in single/dual/quad output mode, with optional die-select on multi-die
// parts, and buffers the bytes in a FIFO popped by the host.
// Ports (top):
//   system_clk, system_reset      clock, async active-high reset
//   start_flag, start_addr,       1-cycle start pulse with range, read mode and
//   end_addr, mode,               die-select enable; latched only while idle
//   switch_die_need
//   spi_read_req                  FIFO pop, one byte per asserted cycle
//   sfr2qspi_io0..3               flash IO lines (MOSI/MISO/WP#/HOLD#)
//   cs_n, spi_clk                 flash chip select and mode-0 clock
//   read_finish                   range done and cs_n released, held until next start
//   rom_data_num                  bytes captured since start
//   fifo_output                   popped byte

// Flash sequencer: die select, command, address, dummy and data capture.
module qspi_read_ctrl #(
  parameter int unsigned CLK_HALF = 2,
  parameter int unsigned DIE_BITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [31:0] end_addr,
  input  logic [1:0]  mode,
  input  logic        switch_die,
  input  logic        fifo_full,
  input  logic [3:0]  io_in,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic        oe0,
  output logic        oe23,
  output logic        push,
  output logic [7:0]  push_data,
  output logic        read_finish,
  output logic [15:0] rom_data_num
);
  localparam int unsigned DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [5:0] GAP_HALVES = 6'd4;

  typedef enum logic [2:0] {IDLE, DIE_SEL, CS_GAP, CMD, ADDR, DUMMY, DATA, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [39:0]      tx;
  logic [7:0]       rx;
  logic [5:0]       cnt;
  logic [3:0]       bcnt;
  logic [15:0]      remaining;
  logic [31:0]      addr;
  logic [1:0]       lane;
  logic             sw;
  logic             die_next;
  logic             read_done;
  logic             tick;
  logic             die_edge;
  logic [3:0]       cpb;
  logic [7:0]       rx_next;

  function automatic logic [7:0] cmd_for(input logic [1:0] m);
    case (m)
      2'd1:    return 8'h3C;
      2'd2:    return 8'h6C;
      default: return 8'h13;
    endcase
  endfunction

  function automatic logic [7:0] die_of(input logic [31:0] a);
    return 8'(a[31:DIE_BITS]);
  endfunction

  assign tick     = (div == DIV_W'(CLK_HALF - 1));
  assign die_edge = sw && (addr[DIE_BITS-1:0] == '0);
  assign mosi     = tx[39];

  // Clocks per byte and the capture shift for the active lane width.
  always_comb begin
    cpb     = 4'd8;
    rx_next = {rx[6:0], io_in[1]};
    case (lane)
      2'd1: begin cpb = 4'd4; rx_next = {rx[5:0], io_in[1], io_in[0]}; end
      2'd2: begin cpb = 4'd2; rx_next = {rx[3:0], io_in}; end
      default: ;
    endcase
  end

  // Sequencer; spi_clk edges happen only on tick, MOSI shifts on falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; div <= '0; tx <= '0; rx <= '0; cnt <= '0; bcnt <= '0;
      remaining <= '0; addr <= '0; lane <= '0; sw <= 1'b0; die_next <= 1'b0;
      cs_n <= 1'b1; sclk <= 1'b0; push <= 1'b0; push_data <= '0;
      read_done <= 1'b0; rom_data_num <= '0;
    end else begin
      push      <= 1'b0;
      read_done <= 1'b0;
      div       <= tick ? '0 : div + DIV_W'(1);
      case (state)
        IDLE: begin
          div  <= '0;
          sclk <= 1'b0;
          if (start) begin
            addr         <= start_addr;
            remaining    <= 16'(end_addr - start_addr + 32'd1);
            lane         <= (mode == 2'b11) ? 2'b00 : mode;
            sw           <= switch_die;
            rom_data_num <= '0;
            if (end_addr < start_addr) begin
              state <= DONE;
            end else if (switch_die) begin
              state <= DIE_SEL; cs_n <= 1'b0; cnt <= 6'd16;
              tx    <= {8'hC2, die_of(start_addr), 24'h0};
            end else begin
              state <= CMD; cs_n <= 1'b0; cnt <= 6'd8;
              tx    <= {cmd_for((mode == 2'b11) ? 2'b00 : mode), start_addr};
            end
          end
        end
        DIE_SEL, CMD, ADDR, DUMMY: begin
          if (tick) begin
            sclk <= ~sclk;
            if (sclk) begin
              tx  <= {tx[38:0], 1'b0};
              cnt <= cnt - 6'd1;
              if (cnt == 6'd1) begin
                case (state)
                  DIE_SEL: begin
                    state <= CS_GAP; cs_n <= 1'b1; cnt <= GAP_HALVES; die_next <= 1'b0;
                  end
                  CMD:  begin state <= ADDR; cnt <= 6'd32; end
                  ADDR: begin
                    if (lane == 2'd0) begin state <= DATA; bcnt <= cpb; end
                    else begin state <= DUMMY; cnt <= 6'd8; end
                  end
                  default: begin state <= DATA; bcnt <= cpb; end
                endcase
              end
            end
          end
        end
        CS_GAP: begin
          if (tick) begin
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              cs_n <= 1'b0;
              if (die_next) begin
                state <= DIE_SEL; cnt <= 6'd16; tx <= {8'hC2, die_of(addr), 24'h0};
              end else begin
                state <= CMD; cnt <= 6'd8; tx <= {cmd_for(lane), addr};
              end
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (!sclk) begin
              // Hold spi_clk low at a byte boundary while the FIFO has no room.
              if (!(bcnt == cpb && fifo_full)) begin
                sclk <= 1'b1;
                rx   <= rx_next;
                if (bcnt == 4'd1) begin
                  push         <= 1'b1;
                  push_data    <= rx_next;
                  rom_data_num <= rom_data_num + 16'd1;
                  remaining    <= remaining - 16'd1;
                  addr         <= addr + 32'd1;
                end
              end
            end else begin
              sclk <= 1'b0;
              if (bcnt == 4'd1) begin
                bcnt <= cpb;
                if (remaining == '0) begin
                  state <= DONE; cs_n <= 1'b1;
                end else if (die_edge) begin
                  state <= CS_GAP; cs_n <= 1'b1; cnt <= GAP_HALVES; die_next <= 1'b1;
                end
              end else begin
                bcnt <= bcnt - 4'd1;
              end
            end
          end
        end
        DONE: begin
          cs_n <= 1'b1; sclk <= 1'b0; read_done <= 1'b1; state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Finish flag is set by the done pulse and cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) read_finish <= 1'b0;
    else if (state == IDLE && start) read_finish <= 1'b0;
    else if (read_done) read_finish <= 1'b1;
  end

  // IO drive enables: io0 carries MOSI only while shifting out; io2/io3 held
  // high except during quad dummy/data where the flash owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe0 <= 1'b0; oe23 <= 1'b0;
    end else begin
      oe0  <= (state == DIE_SEL) || (state == CMD) || (state == ADDR);
      oe23 <= (state != IDLE) && (state != DONE) &&
              ((lane != 2'd2) || !((state == DUMMY) || (state == DATA)));
    end
  end
endmodule

// Top: sequencer plus byte FIFO and IO pad drivers.
module spi_flash_read #(
  parameter int unsigned CLK_HALF   = 2,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned DIE_BITS   = 25
) (
  input  logic        system_clk,
  input  logic        system_reset,
  input  logic        start_flag,
  input  logic [31:0] start_addr,
  input  logic [31:0] end_addr,
  input  logic [1:0]  mode,
  input  logic        switch_die_need,
  input  logic        spi_read_req,
  inout  wire         sfr2qspi_io0,
  inout  wire         sfr2qspi_io1,
  inout  wire         sfr2qspi_io2,
  inout  wire         sfr2qspi_io3,
  output logic        cs_n,
  output logic        spi_clk,
  output logic        read_finish,
  output logic [15:0] rom_data_num,
  output logic [7:0]  fifo_output
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic          mosi, oe0, oe23, push, pop, fifo_full;
  logic [7:0]    push_data;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign sfr2qspi_io0 = oe0  ? mosi : 1'bz;
  assign sfr2qspi_io1 = 1'bz;
  assign sfr2qspi_io2 = oe23 ? 1'b1 : 1'bz;
  assign sfr2qspi_io3 = oe23 ? 1'b1 : 1'bz;

  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = spi_read_req && (count != '0);

  qspi_read_ctrl #(.CLK_HALF(CLK_HALF), .DIE_BITS(DIE_BITS)) qspi_ctrl4read (
    .clk(system_clk), .rst(system_reset), .start(start_flag),
    .start_addr(start_addr), .end_addr(end_addr), .mode(mode),
    .switch_die(switch_die_need), .fifo_full(fifo_full),
    .io_in({sfr2qspi_io3, sfr2qspi_io2, sfr2qspi_io1, sfr2qspi_io0}),
    .cs_n(cs_n), .sclk(spi_clk), .mosi(mosi), .oe0(oe0), .oe23(oe23),
    .push(push), .push_data(push_data), .read_finish(read_finish),
    .rom_data_num(rom_data_num)
  );

  // FIFO storage (no reset needed; pointers define validity).
  always_ff @(posedge system_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and registered pop output.
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0; fifo_output <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        fifo_output <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_read.sv
// Directed bench for spi_flash_read with a behavioural 4-byte-address flash model.
module tb_spi_flash_read;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_flag = 1'b0;
  logic [31:0] start_addr = '0;
  logic [31:0] end_addr = '0;
  logic [1:0]  mode = '0;
  logic        switch_die_need = 1'b0;
  logic        spi_read_req = 1'b0;
  wire         io0, io1, io2, io3;
  logic        cs_n, spi_clk, read_finish;
  logic [15:0] rom_data_num;
  logic [7:0]  fifo_output;

  int passed = 0;
  int total  = 0;

  spi_flash_read dut (
    .system_clk(clk), .system_reset(rst), .start_flag(start_flag),
    .start_addr(start_addr), .end_addr(end_addr), .mode(mode),
    .switch_die_need(switch_die_need), .spi_read_req(spi_read_req),
    .sfr2qspi_io0(io0), .sfr2qspi_io1(io1), .sfr2qspi_io2(io2), .sfr2qspi_io3(io3),
    .cs_n(cs_n), .spi_clk(spi_clk), .read_finish(read_finish),
    .rom_data_num(rom_data_num), .fifo_output(fifo_output)
  );

  always #5 clk = ~clk;

  // Flash model: decodes command/address from io0, returns data after the header.
  int          nclk = 0, last_nclk = 0, width = 0, hdr = 48, cs_falls = 0;
  logic [39:0] shin = '0;
  logic [7:0]  f_cmd = '0;
  logic [31:0] seg_addr = '0;
  logic [3:0]  f_en = '0, f_v = '0;
  logic [7:0]  seg_cmd [$];
  logic [31:0] seg_arg [$];
  bit          use_addr_data = 1'b0;
  logic [7:0]  const_byte = 8'h00;

  assign io0 = f_en[0] ? f_v[0] : 1'bz;
  assign io1 = f_en[1] ? f_v[1] : 1'bz;
  assign io2 = f_en[2] ? f_v[2] : 1'bz;
  assign io3 = f_en[3] ? f_v[3] : 1'bz;

  always @(negedge cs_n) begin
    nclk = 0; shin = '0; f_cmd = '0; width = 0; cs_falls++;
  end

  always @(posedge cs_n) begin
    f_en = 4'b0000; last_nclk = nclk;
  end

  always @(posedge spi_clk) begin
    if (!cs_n) begin
      if (nclk < 40) shin = {shin[38:0], io0};
      nclk++;
      if (nclk == 8) begin
        f_cmd = shin[7:0];
        width = (f_cmd == 8'h3C) ? 2 : (f_cmd == 8'h6C) ? 4 : (f_cmd == 8'h13) ? 1 : 0;
        hdr   = (width == 1) ? 40 : 48;
      end
      if (nclk == 16 && f_cmd == 8'hC2) begin
        seg_cmd.push_back(f_cmd); seg_arg.push_back({24'h0, shin[7:0]});
      end
      if (nclk == 40 && width != 0) begin
        seg_cmd.push_back(f_cmd); seg_arg.push_back(shin[31:0]); seg_addr = shin[31:0];
      end
    end
  end

  always @(negedge spi_clk) begin : flash_drive
    int d, cpb, bi, k;
    logic [7:0] b, sh;
    if (!cs_n && width != 0 && nclk >= hdr) begin
      d   = nclk - hdr;
      cpb = 8 / width;
      bi  = d / cpb;
      k   = d % cpb;
      b   = use_addr_data ? 8'(seg_addr + 32'(bi)) : const_byte;
      sh  = b >> (8 - width * (k + 1));
      case (width)
        1:       begin f_en = 4'b0010; f_v = {2'b00, sh[0], 1'b0}; end
        2:       begin f_en = 4'b0011; f_v = {2'b00, sh[1:0]}; end
        default: begin f_en = 4'b1111; f_v = sh[3:0]; end
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input logic [31:0] sa, input logic [31:0] ea, input logic [1:0] m,
                     input logic s);
    seg_cmd.delete(); seg_arg.delete();
    @(negedge clk);
    start_addr = sa; end_addr = ea; mode = m; switch_die_need = s; start_flag = 1'b1;
    @(negedge clk);
    start_flag = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    int i = 0;
    while (!read_finish && i < budget) begin @(negedge clk); i++; end
    check("finish_reached", 32'(read_finish), 32'd1);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk) spi_read_req = 1'b1;
    @(negedge clk) spi_read_req = 1'b0;
    check(tag, 32'(fifo_output), 32'(exp));
  endtask

  initial begin
    int snap;
    repeat (4) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_read_finish", 32'(read_finish), 32'd0);
    check("rst_rom_data_num", 32'(rom_data_num), 32'd0);
    check("rst_fifo_output", 32'(fifo_output), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single mode, 12 bytes of 0xAA.
    use_addr_data = 1'b0; const_byte = 8'hAA;
    run(32'h0, 32'hB, 2'b00, 1'b0);
    wait_finish(4000);
    check("single_segments", 32'(seg_cmd.size()), 32'd1);
    check("single_cmd", 32'(seg_cmd[0]), 32'h13);
    check("single_addr", seg_arg[0], 32'h0);
    check("single_clocks", 32'(last_nclk), 32'd136);
    check("single_count", 32'(rom_data_num), 32'd12);
    check("single_cs_n", 32'(cs_n), 32'd1);
    for (int k = 0; k < 12; k++) pop_check("single_data", 8'hAA);
    pop_check("empty_pop_holds", 8'hAA);

    // Dual mode, 8 dummy clocks, 0xEE.
    const_byte = 8'hEE;
    run(32'h1000, 32'h100B, 2'b01, 1'b0);
    wait_finish(4000);
    check("dual_cmd", 32'(seg_cmd[0]), 32'h3C);
    check("dual_addr", seg_arg[0], 32'h1000);
    check("dual_clocks", 32'(last_nclk), 32'd96);
    check("dual_count", 32'(rom_data_num), 32'd12);
    for (int k = 0; k < 12; k++) pop_check("dual_data", 8'hEE);

    // Quad mode, 0xBD.
    const_byte = 8'hBD;
    run(32'h2000, 32'h200B, 2'b10, 1'b0);
    wait_finish(4000);
    check("quad_cmd", 32'(seg_cmd[0]), 32'h6C);
    check("quad_addr", seg_arg[0], 32'h2000);
    check("quad_clocks", 32'(last_nclk), 32'd72);
    check("quad_count", 32'(rom_data_num), 32'd12);
    for (int k = 0; k < 12; k++) pop_check("quad_data", 8'hBD);

    // Die crossing with die select; data = low address byte.
    use_addr_data = 1'b1;
    run(32'h01FF_FFFA, 32'h0200_0010, 2'b00, 1'b1);
    wait_finish(8000);
    check("die_segments", 32'(seg_cmd.size()), 32'd4);
    check("die_seg0_cmd", 32'(seg_cmd[0]), 32'hC2);
    check("die_seg0_id", seg_arg[0], 32'h0);
    check("die_seg1_cmd", 32'(seg_cmd[1]), 32'h13);
    check("die_seg1_addr", seg_arg[1], 32'h01FF_FFFA);
    check("die_seg2_cmd", 32'(seg_cmd[2]), 32'hC2);
    check("die_seg2_id", seg_arg[2], 32'h1);
    check("die_seg3_addr", seg_arg[3], 32'h0200_0000);
    check("die_count", 32'(rom_data_num), 32'd23);
    for (int k = 0; k < 23; k++) pop_check("die_data", 8'(32'h01FF_FFFA + 32'(k)));

    // end < start: finish without touching the flash.
    snap = cs_falls;
    run(32'h100, 32'hFF, 2'b00, 1'b0);
    wait_finish(100);
    check("empty_range_no_cs", 32'(cs_falls), 32'(snap));
    check("empty_range_count", 32'(rom_data_num), 32'd0);

    // FIFO full: 260 quad bytes, no pops until the FIFO stalls the clock.
    run(32'h3000, 32'h3103, 2'b10, 1'b0);
    for (int i = 0; i < 6000 && rom_data_num != 16'd256; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    check("full_count_held", 32'(rom_data_num), 32'd256);
    check("full_spi_clk_low", 32'(spi_clk), 32'd0);
    check("full_cs_n_low", 32'(cs_n), 32'd0);
    check("full_not_finished", 32'(read_finish), 32'd0);
    run(32'h0, 32'h0, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    check("busy_start_ignored", 32'(rom_data_num), 32'd256);
    for (int k = 0; k < 260; k++) pop_check("full_data", 8'(k));
    wait_finish(2000);
    check("full_final_count", 32'(rom_data_num), 32'd260);

    // Reset in the middle of data.
    use_addr_data = 1'b0; const_byte = 8'h5A;
    run(32'h0, 32'hFF, 2'b00, 1'b0);
    for (int i = 0; i < 3000 && rom_data_num < 16'd3; i++) @(negedge clk);
    check("mid_reached_data", 32'(rom_data_num >= 16'd3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_spi_clk", 32'(spi_clk), 32'd0);
    check("mid_rst_count", 32'(rom_data_num), 32'd0);
    check("mid_rst_finish", 32'(read_finish), 32'd0);
    check("mid_rst_fifo_output", 32'(fifo_output), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pop_check("mid_rst_fifo_flushed", 8'h00);
    repeat (20) @(negedge clk);
    check("mid_rst_stays_idle", 32'(cs_n), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
